// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } dcache_state_t;

  // Byte-offset bits within one line.
  function automatic int unsigned off_w(input int unsigned line_w);
    return unsigned'($clog2(line_w / 8));
  endfunction

  // Index bits selecting one of the lines.
  function automatic int unsigned idx_w(input int unsigned num_lines);
    return unsigned'($clog2(num_lines));
  endfunction

  // Tag bits left over after index and offset.
  function automatic int unsigned tag_w(input int unsigned addr_w,
                                        input int unsigned line_w,
                                        input int unsigned num_lines);
    return addr_w - idx_w(num_lines) - off_w(line_w);
  endfunction

  // Word-select bits within one line.
  function automatic int unsigned wsel_w(input int unsigned line_w,
                                         input int unsigned data_w);
    return unsigned'($clog2(line_w / data_w));
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Line-granular memory bus between the cache (master) and backing memory (slave).
interface dcache_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
);

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic [LINE_W-1:0] mem_rdata_i;
  logic              mem_ack_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ack_i
  );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: async read by index, one write port that
// either replaces a whole line (refill) or merges one word (store hit).
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned TAG_W     = 22,
  localparam int unsigned IDX_W    = idx_w(NUM_LINES),
  localparam int unsigned WSEL_W   = wsel_w(LINE_W, DATA_W),
  localparam int unsigned WORDS    = LINE_W / DATA_W
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [IDX_W-1:0]               idx_i,
  output logic                           rd_valid_o,
  output logic                           rd_dirty_o,
  output logic [TAG_W-1:0]               rd_tag_o,
  output logic [WORDS-1:0][DATA_W-1:0]   rd_line_o,
  input  logic                           line_we_i,
  input  logic [TAG_W-1:0]               line_tag_i,
  input  logic [LINE_W-1:0]              line_data_i,
  input  logic                           word_we_i,
  input  logic [WSEL_W-1:0]              word_sel_i,
  input  logic [DATA_W-1:0]              word_data_i
);

  logic [NUM_LINES-1:0]           valid_q;
  logic [NUM_LINES-1:0]           dirty_q;
  logic [TAG_W-1:0]               tag_q  [NUM_LINES];
  logic [WORDS-1:0][DATA_W-1:0]   data_q [NUM_LINES];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  // Valid/dirty bits are the only storage cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays: refill replaces the line, store hit merges one word.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[idx_i]  <= line_tag_i;
      data_q[idx_i] <= line_data_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_sel_i] <= word_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate L1 data cache controller:
// same-cycle hits, pipeline stall during writeback/refill, hit/miss counters.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned NUM_LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  dcache_if.master          mem_if,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W  = off_w(LINE_W);
  localparam int unsigned IDX_W  = idx_w(NUM_LINES);
  localparam int unsigned TAG_W  = tag_w(ADDR_W, LINE_W, NUM_LINES);
  localparam int unsigned WSEL_W = wsel_w(LINE_W, DATA_W);
  localparam int unsigned WORDS  = LINE_W / DATA_W;

  dcache_state_t state_q, state_d;
  logic          replay_q, replay_d;
  logic [31:0]   hit_cnt_q, hit_cnt_d;
  logic [31:0]   miss_cnt_q, miss_cnt_d;
  logic [TAG_W-1:0] lat_tag_q, lat_tag_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic              unused_addr_bits;

  logic [IDX_W-1:0]             sram_idx;
  logic                         rd_valid;
  logic                         rd_dirty;
  logic [TAG_W-1:0]             rd_tag;
  logic [WORDS-1:0][DATA_W-1:0] rd_line;
  logic                         hit;
  logic                         stall;
  logic                         word_we;
  logic                         line_we;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [LINE_W-1:0]            mem_wdata;

  assign req_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign req_wsel         = cpu_addr_i[OFF_W-1 -: WSEL_W];
  assign unused_addr_bits = ^cpu_addr_i[OFF_W-WSEL_W-1:0];

  dcache_sram #(
    .DATA_W    (DATA_W),
    .LINE_W    (LINE_W),
    .NUM_LINES (NUM_LINES),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idx_i       (sram_idx),
    .rd_valid_o  (rd_valid),
    .rd_dirty_o  (rd_dirty),
    .rd_tag_o    (rd_tag),
    .rd_line_o   (rd_line),
    .line_we_i   (line_we),
    .line_tag_i  (lat_tag_q),
    .line_data_i (mem_if.mem_rdata_i),
    .word_we_i   (word_we),
    .word_sel_i  (req_wsel),
    .word_data_i (cpu_wdata_i)
  );

  // State, replay flag, counters and latched miss address.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      lat_tag_q  <= '0;
      lat_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      replay_q   <= replay_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      lat_tag_q  <= lat_tag_d;
      lat_idx_q  <= lat_idx_d;
    end
  end

  // Hit detection, miss sequencing and memory bus drive.
  always_comb begin
    state_d    = state_q;
    replay_d   = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    lat_tag_d  = lat_tag_q;
    lat_idx_d  = lat_idx_q;
    sram_idx   = lat_idx_q;
    hit        = 1'b0;
    stall      = 1'b1;
    word_we    = 1'b0;
    line_we    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      IDLE: begin
        sram_idx = req_idx;
        stall    = 1'b0;
        hit      = cpu_req_i & rd_valid & (rd_tag == req_tag);
        if (cpu_req_i && !hit) begin
          stall      = 1'b1;
          miss_cnt_d = miss_cnt_q + 32'd1;
          lat_tag_d  = req_tag;
          lat_idx_d  = req_idx;
          state_d    = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
        if (hit) begin
          word_we = cpu_we_i;
          // The replay after a refill is the original miss, not a new hit.
          if (!replay_q) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, lat_idx_q, {OFF_W{1'b0}}};
        mem_wdata = rd_line;
        if (mem_if.mem_ack_i) begin
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {lat_tag_q, lat_idx_q, {OFF_W{1'b0}}};
        if (mem_if.mem_ack_i) begin
          line_we  = 1'b1;
          replay_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rdata_o        = rd_line[req_wsel];
  assign cpu_stall_o        = stall;
  assign mem_if.mem_req_o   = mem_req;
  assign mem_if.mem_we_o    = mem_we;
  assign mem_if.mem_addr_o  = mem_addr;
  assign mem_if.mem_wdata_o = mem_wdata;
  assign hit_cnt_o          = hit_cnt_q;
  assign miss_cnt_o         = miss_cnt_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a behavioural cache model predicts load
// data, counters and memory traffic; a bench memory answers line requests.
`timescale 1ns/1ps
module tb_dcache_ctrl;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned NUM_LINES = 32;
  localparam int unsigned OFF_W     = 5;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned WORDS     = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  dcache_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mem_if ();

  dcache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .NUM_LINES(NUM_LINES)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cpu_req_i   (cpu_req),
    .cpu_we_i    (cpu_we),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .mem_if      (mem_if),
    .hit_cnt_o   (hit_cnt),
    .miss_cnt_o  (miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                we;
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
  } mem_exp_t;

  typedef struct {
    bit          we;
    logic [31:0] rdata;
    logic [31:0] hits;
    logic [31:0] misses;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference cache model and its view of main memory.
  bit                m_valid [NUM_LINES];
  bit                m_dirty [NUM_LINES];
  logic [31:0]       m_tag   [NUM_LINES];
  logic [LINE_W-1:0] m_line  [NUM_LINES];
  logic [LINE_W-1:0] ref_mem [bit [31:0]];
  int unsigned       m_hits = 0;
  int unsigned       m_misses = 0;

  // Bench memory seen by the DUT.
  logic [LINE_W-1:0] mem [bit [31:0]];
  int unsigned       force_lat = 0;
  int unsigned       lat_sum = 0;
  bit                hold_ack = 1'b0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  function automatic logic [LINE_W-1:0] init_line(input logic [31:0] a);
    logic [LINE_W-1:0] ln;
    for (int w = 0; w < int'(WORDS); w++) begin
      ln[w*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(w) * 32'h01000193) ^ 32'h5A5A0000;
    end
    return ln;
  endfunction

  function automatic logic [LINE_W-1:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
  endfunction

  function automatic logic [LINE_W-1:0] mem_read(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_line(a);
  endfunction

  // One CPU access: predict from the model, drive, wait out the stall.
  task automatic do_op(input bit we, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned idx, w, lb, stalls;
    logic [31:0] tag, la;
    bit hit;
    mem_exp_t m;
    resp_exp_t r;
    idx = (addr >> OFF_W) % NUM_LINES;
    tag = addr >> (OFF_W + IDX_W);
    w   = (addr >> 2) % WORDS;
    la  = (addr >> OFF_W) << OFF_W;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        m.we   = 1'b1;
        m.addr = (m_tag[idx] << (OFF_W + IDX_W)) | (idx << OFF_W);
        m.data = m_line[idx];
        mem_q.push_back(m);
        ref_mem[m.addr] = m_line[idx];
      end
      m.we   = 1'b0;
      m.addr = la;
      m.data = '0;
      mem_q.push_back(m);
      m_line[idx]  = ref_read(la);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
    end
    r.we     = we;
    r.rdata  = m_line[idx][w*32 +: 32];
    r.hits   = m_hits;
    r.misses = m_misses;
    resp_q.push_back(r);
    if (hit) m_hits++;
    if (we) begin
      m_line[idx][w*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end
    lb = lat_sum;
    stalls = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      stalls++;
      if (stalls > 200) begin
        chk("stall_timeout", 1, 0);
        finish_run();
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    chk("stall_cycles", stalls, hit ? 0 : 1 + lat_sum - lb);
  endtask

  // Memory responder: random (or forced) ack latency, counted from req rise.
  initial begin
    int unsigned cnt, lat;
    cnt = 0; lat = 1;
    mem_if.mem_ack_i   = 1'b0;
    mem_if.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (hold_ack) begin
        cnt = 0;
        continue;
      end
      mem_if.mem_ack_i = 1'b0;
      if (mem_if.mem_req_o === 1'b1) begin
        if (cnt == 0) lat = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
        cnt++;
        if (cnt == lat) begin
          mem_if.mem_ack_i = 1'b1;
          if (mem_if.mem_we_o) mem[mem_if.mem_addr_o] = mem_if.mem_wdata_o;
          else mem_if.mem_rdata_i = mem_read(mem_if.mem_addr_o);
          lat_sum += lat;
          cnt = 0;
        end
      end
    end
  end

  // Monitor: compare CPU responses and completed memory transfers.
  initial begin
    resp_exp_t r;
    mem_exp_t m;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (cpu_req && !cpu_stall) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
          r = resp_q.pop_front();
          if (!r.we) chk("load_data", cpu_rdata, r.rdata);
          chk("hit_cnt", hit_cnt, r.hits);
          chk("miss_cnt", miss_cnt, r.misses);
        end
      end
      if (mem_if.mem_req_o && mem_if.mem_ack_i) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          m = mem_q.pop_front();
          chk("mem_we", mem_if.mem_we_o, m.we);
          chk("mem_addr", mem_if.mem_addr_o, m.addr);
          if (m.we) chk("mem_wdata", mem_if.mem_wdata_o, m.data);
        end
      end
    end
  end

  // Stimulus.
  initial begin
    logic [LINE_W-1:0] l;
    bit seen;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_mem_req", mem_if.mem_req_o, 0);
    chk("rst_mem_we", mem_if.mem_we_o, 0);
    chk("rst_mem_addr", mem_if.mem_addr_o, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;

    l = init_line(32'h40);
    l[31:0] = 32'hDEADBEEF;
    mem[32'h40] = l;
    ref_mem[32'h40] = l;

    force_lat = 3;
    do_op(1'b0, 32'h0000_0040, 32'h0);
    force_lat = 0;
    do_op(1'b1, 32'h0000_0044, 32'h1234_5678);
    do_op(1'b0, 32'h0000_0044, 32'h0);
    do_op(1'b0, 32'h0000_0440, 32'h0);

    // Reset while a refill is outstanding; a late ack must be ignored.
    hold_ack = 1'b1;
    mem_if.mem_ack_i = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0060;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_if.mem_req_o) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("alloc_req_seen", seen, 1);
    chk("alloc_we", mem_if.mem_we_o, 0);
    chk("alloc_addr", mem_if.mem_addr_o, 32'h60);
    rst = 1'b1; cpu_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_mem_req", mem_if.mem_req_o, 0);
    chk("abort_stall", cpu_stall, 0);
    chk("abort_miss_cnt", miss_cnt, 0);
    @(posedge clk); #1;
    mem_if.mem_ack_i = 1'b1;
    mem_if.mem_rdata_i = init_line(32'h60);
    @(negedge clk);
    chk("late_ack_mem_req", mem_if.mem_req_o, 0);
    @(posedge clk); #1;
    mem_if.mem_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_stall", cpu_stall, 0);
    chk("late_ack_hits", hit_cnt, 0);
    chk("pending_mem_q", mem_q.size(), 0);
    chk("pending_resp_q", resp_q.size(), 0);
    hold_ack = 1'b0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
    end
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1;

    do_op(1'b0, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 10; i++) begin
      do_op(1'(i % 2), 32'h40 + 32'((i % 8) * 4), $urandom);
    end
    @(negedge clk);
    chk("hit_cnt_after_10", hit_cnt, 10);
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      do_op(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_resp_q", resp_q.size(), 0);
    chk("final_mem_q", mem_q.size(), 0);
    chk("final_hits", hit_cnt, m_hits);
    chk("final_misses", miss_cnt, m_misses);
    finish_run();
  end

endmodule
